// File: rtl/sfft_pkg.sv
// Shared defaults and FSM encoding for the second-FFT peak finder.
package sfft_pkg;

  localparam int unsigned DATA_W_DEF = 40;
  localparam int unsigned N_BINS_DEF = 16;
  localparam int unsigned IDX_W_DEF  = 7;
  localparam int unsigned K_W_DEF    = 4;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/sfft_power.sv
// Three-stage I^2+Q^2 pipeline (capture, square, sum) with a tag carried alongside.
module sfft_power #(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned TAG_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2*DATA_W-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_pow,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy_c
);

  logic                       v1, v2;
  logic signed [DATA_W-1:0]   s1_i, s1_q;
  logic [TAG_W-1:0]           t1, t2;
  logic [2*DATA_W-1:0]        sq_i, sq_q;
  logic signed [2*DATA_W-1:0] ie, qe;

  // Sign-extend to full product width so the square is exact for -2^(DATA_W-1).
  assign ie = {{DATA_W{s1_i[DATA_W-1]}}, s1_i};
  assign qe = {{DATA_W{s1_q[DATA_W-1]}}, s1_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      t1        <= '0;
      t2        <= '0;
      sq_i      <= '0;
      sq_q      <= '0;
      out_pow   <= '0;
      out_tag   <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        s1_i <= in_data[DATA_W-1:0];
        s1_q <= in_data[2*DATA_W-1:DATA_W];
        t1   <= in_tag;
      end
      if (v1) begin
        sq_i <= ie * ie;
        sq_q <= qe * qe;
        t2   <= t1;
      end
      if (v2) begin
        out_pow <= sq_i + sq_q;
        out_tag <= t2;
      end
    end
  end

  assign busy_c = v1 | v2 | out_valid;

endmodule

// File: rtl/sfft_peak_finder.sv
// Per-frame peak search over second-FFT bins with length/index integrity flag.
module sfft_peak_finder
  import sfft_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_BINS = N_BINS_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned K_W    = K_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] s_data,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic [IDX_W-1:0]    s_index,
  input  logic [K_W-1:0]      s_k,
  output logic                s_ready,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [IDX_W-1:0]    m_index,
  output logic [K_W-1:0]      m_peak_k,
  output logic [2*DATA_W-1:0] m_peak_pow,
  output logic                m_err
);

  localparam int unsigned CNT_W = $clog2(N_BINS + 1);
  localparam int unsigned TAG_W = K_W + IDX_W + 2;

  state_t              state_q, state_nx;
  logic                s_ready_nx, m_valid_nx, load_out_c;
  logic [CNT_W-1:0]    beat_cnt, cnt_nx;
  logic [IDX_W-1:0]    frm_index;
  logic                accept_c, first_c, close_c, beat_err_c;

  logic                p_valid, busy_c;
  logic [2*DATA_W-1:0] p_pow;
  logic [TAG_W-1:0]    p_tag;
  logic [K_W-1:0]      p_k;
  logic [IDX_W-1:0]    p_idx;
  logic                p_err, p_close;

  logic [2*DATA_W-1:0] acc_max;
  logic [K_W-1:0]      acc_k;
  logic [IDX_W-1:0]    acc_index;
  logic                acc_err, acc_seed;

  // Input-side framing: beat count, first-beat index latch, per-beat error.
  assign accept_c   = s_valid & s_ready;
  assign cnt_nx     = beat_cnt + CNT_W'(1);
  assign first_c    = (beat_cnt == '0);
  assign close_c    = s_last | (cnt_nx == CNT_W'(N_BINS));
  assign beat_err_c = (s_last ^ (cnt_nx == CNT_W'(N_BINS))) |
                      (~first_c & (s_index != frm_index));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt  <= '0;
      frm_index <= '0;
    end else if (accept_c) begin
      beat_cnt <= close_c ? '0 : cnt_nx;
      if (first_c) frm_index <= s_index;
    end
  end

  sfft_power #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_power (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_c),
    .in_data   (s_data),
    .in_tag    ({s_k, s_index, beat_err_c, close_c}),
    .out_valid (p_valid),
    .out_pow   (p_pow),
    .out_tag   (p_tag),
    .busy_c    (busy_c)
  );

  assign {p_k, p_idx, p_err, p_close} = p_tag;

  // Running max: first beat of a frame seeds, later beats win only if strictly larger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_max   <= '0;
      acc_k     <= '0;
      acc_index <= '0;
      acc_err   <= 1'b0;
      acc_seed  <= 1'b1;
    end else if (p_valid) begin
      if (acc_seed || (p_pow > acc_max)) begin
        acc_max <= p_pow;
        acc_k   <= p_k;
      end
      if (acc_seed) begin
        acc_index <= p_idx;
        acc_err   <= p_err;
      end else begin
        acc_err <= acc_err | p_err;
      end
      acc_seed <= p_close;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ACCUM;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx   = state_q;
    load_out_c = 1'b0;
    case (state_q)
      ST_ACCUM: if (accept_c && close_c) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (!busy_c) begin
          state_nx   = ST_OUT;
          load_out_c = 1'b1;
        end
      end
      ST_OUT:   if (m_ready) state_nx = ST_ACCUM;
      default:  state_nx = ST_ACCUM;
    endcase
    s_ready_nx = (state_nx == ST_ACCUM);
    m_valid_nx = (state_nx == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_index    <= '0;
      m_peak_k   <= '0;
      m_peak_pow <= '0;
      m_err      <= 1'b0;
    end else begin
      s_ready <= s_ready_nx;
      m_valid <= m_valid_nx;
      if (load_out_c) begin
        m_index    <= acc_index;
        m_peak_k   <= acc_k;
        m_peak_pow <= acc_max;
        m_err      <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_sfft_peak_finder.sv
// Scoreboard bench for sfft_peak_finder: directed frames with hand-computed peaks.
module tb_sfft_peak_finder;

  logic        clk;
  logic        rst;
  logic [79:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [6:0]  s_index;
  logic [3:0]  s_k;
  logic        s_ready;
  logic        m_valid;
  logic        m_ready;
  logic [6:0]  m_index;
  logic [3:0]  m_peak_k;
  logic [79:0] m_peak_pow;
  logic        m_err;

  sfft_peak_finder dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_index    (s_index),
    .s_k        (s_k),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_index    (m_index),
    .m_peak_k   (m_peak_k),
    .m_peak_pow (m_peak_pow),
    .m_err      (m_err)
  );

  typedef struct {
    logic [6:0]  idx;
    logic [3:0]  k;
    logic [79:0] pow;
    logic        err;
    int          close_edge;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic signed [39:0] fi   [16];
  logic signed [39:0] fq   [16];
  logic [6:0]         fidx [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_frame(input logic [6:0] idx);
    for (int b = 0; b < 16; b++) begin
      fi[b]   = '0;
      fq[b]   = '0;
      fidx[b] = idx;
    end
  endtask

  task automatic send_frame(input int nb, input bit last_at_end, input bit closes,
                            input bit gaps, input logic [6:0] e_idx,
                            input logic [3:0] e_k, input logic [79:0] e_pow,
                            input logic e_err);
    exp_t e;
    int   w;
    for (int b = 0; b < nb; b++) begin
      if (gaps && (b % 3 == 1)) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {fq[b], fi[b]};
      s_index = fidx[b];
      s_k     = 4'(b);
      s_last  = last_at_end && (b == nb - 1);
      w = 0;
      while (!s_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!s_ready) chk("s_ready_timeout", 80'd0, 80'd1);
      if (closes && b == nb - 1) begin
        e.idx = e_idx; e.k = e_k; e.pow = e_pow; e.err = e_err;
        e.close_edge = cyc + 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((q.size() != 0 || m_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("idle_timeout", 80'd0, 80'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_s_ready"}, 80'(s_ready), 80'd0);
    chk({tag, "_m_valid"}, 80'(m_valid), 80'd0);
    chk({tag, "_m_err"}, 80'(m_err), 80'd0);
    chk({tag, "_m_index"}, 80'(m_index), 80'd0);
    chk({tag, "_m_peak_k"}, 80'(m_peak_k), 80'd0);
    chk({tag, "_m_peak_pow"}, m_peak_pow, 80'd0);
  endtask

  // Monitor: samples mid-cycle, compares every presented result against the queue head.
  initial begin : monitor
    exp_t e;
    bit   prev_mv  = 1'b0;
    bit   ready_due = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_mv   = 1'b0;
        ready_due = 1'b0;
      end else begin
        if (ready_due) begin
          chk("s_ready_after_handoff", 80'(s_ready), 80'd1);
          ready_due = 1'b0;
        end
        if (m_valid) begin
          if (q.size() == 0) begin
            chk("spurious_m_valid", 80'd1, 80'd0);
          end else begin
            e = q[0];
            if (!prev_mv) chk("latency", 80'(cyc), 80'(e.close_edge + 4));
            chk("m_index", 80'(m_index), 80'(e.idx));
            chk("m_peak_k", 80'(m_peak_k), 80'(e.k));
            chk("m_peak_pow", m_peak_pow, e.pow);
            chk("m_err", 80'(m_err), 80'(e.err));
            chk("s_ready_low", 80'(s_ready), 80'd0);
            if (m_ready) begin
              void'(q.pop_front());
              ready_due = 1'b1;
            end
          end
        end
        prev_mv = m_valid;
      end
    end
  end

  initial begin : stim
    int w;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_index = '0; s_k = '0;
    m_ready = 1'b1;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1 chk_zero_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("s_ready_after_release", 80'(s_ready), 80'd1);

    // Single tone at k=5: 3^2+4^2 = 25
    clear_frame(7'd9);
    fi[5] = 40'sd4; fq[5] = 40'sd3;
    send_frame(16, 1'b1, 1'b1, 1'b1, 7'd9, 4'd5, 80'd25, 1'b0);
    wait_idle();

    // Tie at power 100 (k=3 and k=11): earliest wins
    clear_frame(7'd2);
    for (int b = 0; b < 16; b++) fi[b] = 40'sd1;
    fi[3]  = 40'sd6;   fq[3] = 40'sd8;
    fi[11] = -40'sd10; fq[11] = 40'sd0;
    send_frame(16, 1'b1, 1'b1, 1'b0, 7'd2, 4'd3, 80'd100, 1'b0);
    wait_idle();

    // Most negative I and Q: 2*(2^39)^2 = 2^79; k=15 just below
    clear_frame(7'd127);
    fi[0]  = 40'sh80_0000_0000; fq[0]  = 40'sh80_0000_0000;
    fi[15] = 40'sh7F_FFFF_FFFF; fq[15] = 40'sh7F_FFFF_FFFF;
    send_frame(16, 1'b1, 1'b1, 1'b0, 7'd127, 4'd0, (80'd1 << 79), 1'b0);
    wait_idle();

    // All-zero frame reports its first bin
    clear_frame(7'd4);
    send_frame(16, 1'b1, 1'b1, 1'b1, 7'd4, 4'd0, 80'd0, 1'b0);
    wait_idle();

    // Short frame: s_last on beat 12
    clear_frame(7'd5);
    fi[7] = -40'sd3;
    send_frame(12, 1'b1, 1'b1, 1'b0, 7'd5, 4'd7, 80'd9, 1'b1);
    wait_idle();

    // Index changes on beat 10
    clear_frame(7'd6);
    fi[2] = 40'sd2;
    fidx[10] = 7'd7;
    send_frame(16, 1'b1, 1'b1, 1'b0, 7'd6, 4'd2, 80'd4, 1'b1);
    wait_idle();

    // Sixteen beats without s_last: closes at beat 16 with error
    clear_frame(7'd3);
    fi[9] = 40'sd1; fq[9] = 40'sd1;
    send_frame(16, 1'b0, 1'b1, 1'b0, 7'd3, 4'd9, 80'd2, 1'b1);
    wait_idle();

    // Backpressure: hold m_ready low 20 cycles; 100^2+100^2 = 20000
    m_ready = 1'b0;
    clear_frame(7'd10);
    fi[14] = 40'sd100; fq[14] = -40'sd100;
    send_frame(16, 1'b1, 1'b1, 1'b0, 7'd10, 4'd14, 80'd20000, 1'b0);
    w = 0;
    while (!m_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!m_valid) chk("stall_valid_timeout", 80'd0, 80'd1);
    repeat (20) @(negedge clk);
    m_ready = 1'b1;
    wait_idle();

    // Reset after beat 8 of a frame, then a clean frame
    clear_frame(7'd11);
    fi[1] = 40'sd50;
    send_frame(8, 1'b0, 1'b0, 1'b0, 7'd11, 4'd0, 80'd0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    clear_frame(7'd12);
    fi[6] = 40'sd7;
    send_frame(16, 1'b1, 1'b1, 1'b1, 7'd12, 4'd6, 80'd49, 1'b0);
    wait_idle();

    chk("queue_empty", 80'(q.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sfft_peak_finder.md
SFFT_PEAK_FINDER -- requirements
Module: sfft_peak_finder

Interface
REQ-001 SHALL have parameter DATA_W, default 40, signed width of each I/Q component.
REQ-002 SHALL have parameter N_BINS, default 16, beats per frame (second-FFT length).
REQ-003 SHALL have parameter IDX_W, default 7, channel index width.
REQ-004 SHALL have parameter K_W, default 4, bin-number width.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port s_data  input  2*DATA_W  second-FFT bin, {Q[79:40], I[39:0]}, two's complement.
REQ-008 SHALL have port s_valid  input  1  s_data/s_index/s_k/s_last valid.
REQ-009 SHALL have port s_last  input  1  final beat of frame.
REQ-010 SHALL have port s_index  input  IDX_W  channel index of frame.
REQ-011 SHALL have port s_k  input  K_W  bin number of beat.
REQ-012 SHALL have port s_ready  output  1  beat accepted when s_valid & s_ready.
REQ-013 SHALL have port m_valid  output  1  result valid.
REQ-014 SHALL have port m_ready  input  1  result consumed when m_valid & m_ready.
REQ-015 SHALL have port m_index  output  IDX_W  channel index of result.
REQ-016 SHALL have port m_peak_k  output  K_W  bin with maximum power.
REQ-017 SHALL have port m_peak_pow  output  2*DATA_W  I^2+Q^2 of peak bin, unsigned.
REQ-018 SHALL have port m_err  output  1  frame malformed (length or index mismatch).

Function
REQ-019 SHALL compute power per accepted beat as I*I+Q*Q, full precision, unsigned 2*DATA_W bits (no saturation; -2^39 squared fits).
REQ-020 SHALL pipeline power in 3 register stages (capture, square, sum); beat tags k/last/index SHALL travel alongside.
REQ-021 SHALL update running max only when new power strictly greater than stored max; ties keep lowest-arrival k.
REQ-022 SHALL seed running max with first beat of each frame regardless of value (zero-power frame reports its first k).
REQ-023 SHALL latch s_index on first beat; any later beat with different s_index SHALL set err for that frame.
REQ-024 SHALL count beats; s_last on beat count != N_BINS, or beat N_BINS without s_last, SHALL set err; in the latter case frame closes at beat N_BINS.
REQ-025 SHALL implement FSM ACCUM -> DRAIN (on accepted closing beat) -> OUT (pipeline empty) -> ACCUM (on m_valid & m_ready).
REQ-026 SHALL drive s_ready=1 only in ACCUM; closing beat accepted, then s_ready=0 until result handed off.
REQ-027 SHALL assert m_valid exactly 4 cycles after closing-beat acceptance; m_index/m_peak_k/m_peak_pow/m_err stable while m_valid & ~m_ready.
REQ-028 SHALL return s_ready=1 on the cycle after handoff; no bubble beyond that one cycle.
REQ-029 SHALL ignore s_k for peak selection beyond reporting; m_peak_k is s_k of winning beat.
REQ-030 SHALL tolerate s_valid gaps mid-frame with no effect on result.

Reset
REQ-031 SHALL on rst=0 immediately clear: s_ready=0, m_valid=0, m_err=0, m_index=0, m_peak_k=0, m_peak_pow=0, pipeline valids, beat counter; FSM -> ACCUM.
REQ-032 SHALL assert s_ready=1 on the first clk edge after rst release.
REQ-033 SHALL discard any partial frame or pending result when reset asserts mid-operation.

Structure
REQ-034 SHALL place DATA_W, IDX_W, K_W, N_BINS defaults and the FSM state encoding in shared package sfft_pkg.
REQ-035 SHALL implement squaring/summing pipeline as sub-module sfft_power (3-stage, valid-tagged).

Verification
REQ-036 SHALL test: 16 beats, bin k=5 = {Q=3,I=4}, others 0, index 9 -> m_index=9, m_peak_k=5, m_peak_pow=25, m_err=0, m_valid 4 cycles after last.
REQ-037 SHALL test: bins 3 and 11 both power 100, rest 1 -> m_peak_k=3.
REQ-038 SHALL test: I=Q=-2^39 at k=0 -> m_peak_pow=2^79, no overflow.
REQ-039 SHALL test: s_last on beat 12, then index change mid-frame on next frame -> m_err=1 both results.
REQ-040 SHALL test: m_ready=0 for 20 cycles -> outputs stable, s_ready=0 throughout, s_ready=1 cycle after handoff.
REQ-041 SHALL test: rst=0 at beat 8 -> all outputs 0 asynchronously, next full frame reports correctly.
